digit_merger: RTL
=================

// Module: digit_merger
// PURPOSE
//  Sequential BCD-to-binary converter: takes four BCD digits (thousands..ones)
//  and produces the 14-bit binary value 0..9999, one digit per clock via
//  shift-and-add (acc*10 + digit). Sits between the digit-entry/display
//  domain and the binary counters of the timer, e.g. to load a user-set value.
//  Start/busy/done handshake; digits above 9 are flagged, not converted.
// PARAMETERS
//  NUM_DIGITS  4   number of BCD digits consumed; fixed at 4 for this design
//  SUM_W       14  width of binary result; must hold 10**NUM_DIGITS-1
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  reset       in   1      asynchronous, active-high; clears all state
//  start       in   1      request conversion; sampled only in IDLE
//  digit_1000  in   4      thousands digit, sampled with start
//  digit_100   in   4      hundreds digit, sampled with start
//  digit_10    in   4      tens digit, sampled with start
//  digit_1     in   4      ones digit, sampled with start
//  busy        out  1      high while a conversion is in progress (CALC, DONE)
//  done        out  1      one-cycle pulse: sum/err valid and updated
//  sum         out  14     binary result; held from done until next done
//  err         out  1      1 = a latched digit was >9; held like sum
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, sum=0, err=0, internal acc/count=0.
//  Reset mid-conversion aborts immediately: no done pulse, outputs as above.
//  FSM states: IDLE, CALC, DONE.
//   IDLE: on start=1 at edge E: latch all 4 digits into a shift register,
//         acc<=0, cnt<=0, bad<=(any digit>9); go CALC. start=0: stay.
//   CALC: each edge: acc <= (acc<<3)+(acc<<1)+cur_digit, digits consumed
//         MSD first (1000,100,10,1); cnt++. After 4th accumulate (edge E+4)
//         go DONE, sum<=bad?0:new acc, err<=bad, done<=1.
//   DONE: one cycle; done=1; next edge -> IDLE, done<=0.
//  Latency: done high in the cycle after edge E+4 (4 cycles after start
//  sampled). busy=1 from after edge E through the done cycle inclusive.
//  start while busy (CALC or DONE, incl. the done cycle) is ignored; no
//  queuing. Input digits may change after edge E without effect.
//  Arithmetic: acc SUM_W bits; max 9999 < 2**14, no overflow possible for
//  valid digits; invalid digits still shift through (acc may wrap) but
//  result is discarded: sum=0, err=1.
//  sum/err change only at the edge that raises done (or reset).
//  Next start accepted in IDLE one cycle after done; back-to-back throughput
//  = one conversion per 6 cycles.
// TESTING
//  1) digits 1,2,3,4, start 1 cycle -> done exactly 4 cycles after start
//     edge, sum=1234 (14'h04D2), err=0, busy high 5 cycles.
//  2) digits 9,9,9,9 -> sum=9999 (14'h270F), err=0; digits 0,0,0,0 -> sum=0.
//  3) digits 0,4'hA,0,5 -> done in 4 cycles, sum=0, err=1; following
//     0,0,0,7 -> sum=7, err=0.
//  4) start held high 10 cycles with 5,6,7,8, digits changed to 1,1,1,1
//     after first edge -> first done sum=5678; second conversion starts in
//     the IDLE cycle after done and yields 1111; start pulses in CALC ignored.
//  5) reset asserted asynchronously 2 cycles into CALC -> busy/done/sum/err
//     drop to 0 without clock; no done pulse; next start converts normally.
//  6) exhaustive 0..9999: drive digits from value, compare sum==value, err=0.

Source files
------------

// File: rtl/digit_merger.sv
// Sequential BCD-to-binary converter: four BCD digits, MSD first, folded into
// a binary accumulator as acc*10 + digit, one digit per clock.
module digit_merger #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SUM_W      = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       digit_1000,
  input  logic [3:0]       digit_100,
  input  logic [3:0]       digit_10,
  input  logic [3:0]       digit_1,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum,
  output logic             err
);

  localparam int unsigned SR_W  = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SR_W-1:0]  digits_q, digits_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_q, bad_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             err_q, err_d;

  logic [SR_W-1:0]  in_digits;
  logic             in_bad;
  logic             last_digit;
  logic [SUM_W-1:0] acc_next;

  assign in_digits  = {digit_1000, digit_100, digit_10, digit_1};
  assign last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));
  // acc*10 as (acc<<3)+(acc<<1); wraps harmlessly on invalid digits
  assign acc_next   = (acc_q << 3) + (acc_q << 1) + SUM_W'(digits_q[SR_W-1 -: 4]);

  always_comb begin
    in_bad = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (in_digits[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_digit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    digits_d = digits_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    sum_d    = sum_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          digits_d = in_digits;
          acc_d    = '0;
          cnt_d    = '0;
          bad_d    = in_bad;
        end
      end
      CALC: begin
        acc_d    = acc_next;
        digits_d = {digits_q[SR_W-5:0], 4'd0};
        cnt_d    = cnt_q + 1'b1;
        if (last_digit) begin
          sum_d = bad_q ? '0 : acc_next;
          err_d = bad_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      bad_q    <= 1'b0;
      sum_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      bad_q    <= bad_d;
      sum_q    <= sum_d;
      err_q    <= err_d;
    end
  end

  assign sum = sum_q;
  assign err = err_q;

endmodule
